// File: rtl/clock_face_renderer.sv
// clock_face_renderer: pixel stage behind the VGA timing generator.
// Keeps BCD wall-clock time advanced by frame counting and set by two
// buttons, draws HH:MM as four seven-segment digits plus a colon, and
// registers RGB together with one-cycle-delayed sync outputs.
// Optional build macro: CLOCK_FACE_COLON_BLINK_EN (colon blinks with seconds[0]).
module clock_face_renderer #(
    parameter int FRAMES_PER_SEC = 75,
    parameter int X0             = 144,
    parameter int Y0             = 168,
    parameter int DIG_W          = 80,
    parameter int DIG_H          = 144,
    parameter int SEG_T          = 16,
    parameter int PITCH          = 96
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] vga_x,
    input  logic [9:0] vga_y,
    input  logic       vga_visible,
    input  logic       vga_vertical_blank_strobe,
    input  logic       vga_hs_in,
    input  logic       vga_vs_in,
    input  logic       hour_button,
    input  logic       minute_button,
    output logic [1:0] vga_r,
    output logic [1:0] vga_g,
    output logic [1:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic [7:0] seconds
);

    localparam int FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_SEC - 1);

    // Cell-local geometry, all 11-bit so the right edge never wraps
    localparam logic [10:0] Y0_L    = 11'(Y0);
    localparam logic [10:0] W_L     = 11'(DIG_W);
    localparam logic [10:0] H_L     = 11'(DIG_H);
    localparam logic [10:0] T_L     = 11'(SEG_T);
    localparam logic [10:0] HALF_L  = 11'(DIG_H / 2);
    localparam logic [10:0] RIGHT_L = 11'(DIG_W - SEG_T);
    localparam logic [10:0] BOT_L   = 11'(DIG_H - SEG_T);
    localparam logic [10:0] G0_L    = 11'(DIG_H / 2 - SEG_T / 2);
    localparam logic [10:0] G1_L    = 11'(DIG_H / 2 + SEG_T / 2);

    // Colon squares are centred horizontally in the gap after digit 1
    localparam logic [10:0] CX_L  = 11'(X0 + PITCH + DIG_W + (PITCH - DIG_W - SEG_T) / 2);
    localparam logic [10:0] CY0_L = 11'(Y0 + 40);
    localparam logic [10:0] CY1_L = 11'(Y0 + 96);

    // BCD increment that wraps to 00 after the given last value
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        logic [7:0] r;
        if (v == last) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Segment mask ordered {a,b,c,d,e,f,g}
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] m;
        case (d)
            4'd0:    m = 7'b1111110;
            4'd1:    m = 7'b0110000;
            4'd2:    m = 7'b1101101;
            4'd3:    m = 7'b1111001;
            4'd4:    m = 7'b0110011;
            4'd5:    m = 7'b1011011;
            4'd6:    m = 7'b1011111;
            4'd7:    m = 7'b1110000;
            4'd8:    m = 7'b1111111;
            4'd9:    m = 7'b1111011;
            default: m = 7'b0000000;
        endcase
        return m;
    endfunction

    logic            hr_sync1_q, hr_sync1_d, hr_sync2_q, hr_sync2_d;
    logic            mn_sync1_q, mn_sync1_d, mn_sync2_q, mn_sync2_d;
    logic            hr_prev_q, hr_prev_d, mn_prev_q, mn_prev_d;
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]      sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [1:0]      r_q, r_d, g_q, g_d, b_q, b_d;
    logic            hs_q, hs_d, vs_q, vs_d;

    logic hour_press, min_press, tick, min_carry, hour_adv;

    // Button synchronizers, frame-rate press sampling and time keeping
    always_comb begin
        hr_sync1_d  = hour_button;
        hr_sync2_d  = hr_sync1_q;
        mn_sync1_d  = minute_button;
        mn_sync2_d  = mn_sync1_q;
        hr_prev_d   = hr_prev_q;
        mn_prev_d   = mn_prev_q;
        frame_cnt_d = frame_cnt_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;

        hour_press = vga_vertical_blank_strobe && hr_sync2_q && !hr_prev_q;
        min_press  = vga_vertical_blank_strobe && mn_sync2_q && !mn_prev_q;
        tick       = vga_vertical_blank_strobe && (frame_cnt_q == FC_LAST);
        min_carry  = tick && (sec_q == 8'h59) && (min_q == 8'h59);
        // A minute press discards the tick, so its hour carry is dropped too;
        // a press and a carry in the same frame still advance hours only once.
        hour_adv   = hour_press || (!min_press && min_carry);

        if (vga_vertical_blank_strobe) begin
            hr_prev_d   = hr_sync2_q;
            mn_prev_d   = mn_sync2_q;
            frame_cnt_d = tick ? '0 : frame_cnt_q + FC_W'(1);
        end

        if (min_press) begin
            min_d       = bcd_inc(min_q, 8'h59);
            sec_d       = 8'h00;
            frame_cnt_d = '0;
        end else if (tick) begin
            sec_d = bcd_inc(sec_q, 8'h59);
            if (sec_q == 8'h59) begin
                min_d = bcd_inc(min_q, 8'h59);
            end
        end

        if (hour_adv) begin
            hour_d = bcd_inc(hour_q, 8'h23);
        end
    end

    logic [10:0] x11, y11;
    logic [15:0] digits;
    logic [3:0]  lit;
    logic        colon_px, colon_on;

    assign x11    = {1'b0, vga_x};
    assign y11    = {1'b0, vga_y};
    assign digits = {hour_q, min_q};

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        localparam logic [10:0] OX = 11'(X0 + gi * PITCH);
        logic [10:0] lx, ly;
        logic        in_cell, upper, left, right;
        logic [6:0]  mask, hit;

        assign lx      = x11 - OX;
        assign ly      = y11 - Y0_L;
        assign in_cell = (x11 >= OX) && (lx < W_L) && (y11 >= Y0_L) && (ly < H_L);
        assign mask    = seg_decode(digits[15 - 4 * gi -: 4]);
        assign upper   = ly < HALF_L;
        assign left    = lx < T_L;
        assign right   = lx >= RIGHT_L;
        assign hit     = {ly < T_L, right && upper, right && !upper, ly >= BOT_L,
                          left && !upper, left && upper, (ly >= G0_L) && (ly < G1_L)};
        assign lit[gi] = in_cell && |(hit & mask);
    end

    assign colon_px = (x11 >= CX_L) && (x11 < CX_L + T_L) &&
                      (((y11 >= CY0_L) && (y11 < CY0_L + T_L)) ||
                       ((y11 >= CY1_L) && (y11 < CY1_L + T_L)));

`ifdef CLOCK_FACE_COLON_BLINK_EN
    assign colon_on = !sec_q[0];
`else
    assign colon_on = 1'b1;
`endif

    // Pixel colour and sync for the current input cycle, registered together
    always_comb begin
        r_d  = 2'd0;
        g_d  = 2'd0;
        b_d  = 2'd0;
        hs_d = vga_hs_in;
        vs_d = vga_vs_in;
        if (vga_visible) begin
            if (|lit) begin
                r_d = 2'd3;
                g_d = 2'd3;
            end else if (colon_px && colon_on) begin
                r_d = 2'd3;
                g_d = 2'd3;
                b_d = 2'd3;
            end else begin
                b_d = 2'd1;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            hr_sync1_q  <= 1'b0;
            hr_sync2_q  <= 1'b0;
            mn_sync1_q  <= 1'b0;
            mn_sync2_q  <= 1'b0;
            hr_prev_q   <= 1'b0;
            mn_prev_q   <= 1'b0;
            frame_cnt_q <= '0;
            sec_q       <= 8'h00;
            min_q       <= 8'h00;
            hour_q      <= 8'h00;
            r_q         <= 2'd0;
            g_q         <= 2'd0;
            b_q         <= 2'd0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
        end else begin
            hr_sync1_q  <= hr_sync1_d;
            hr_sync2_q  <= hr_sync2_d;
            mn_sync1_q  <= mn_sync1_d;
            mn_sync2_q  <= mn_sync2_d;
            hr_prev_q   <= hr_prev_d;
            mn_prev_q   <= mn_prev_d;
            frame_cnt_q <= frame_cnt_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
        end
    end

    assign vga_r   = r_q;
    assign vga_g   = g_q;
    assign vga_b   = b_q;
    assign vga_hs  = hs_q;
    assign vga_vs  = vs_q;
    assign seconds = sec_q;

endmodule

// File: tb/tb_clock_face_renderer.sv
// Testbench for clock_face_renderer: table-driven pixel vectors, directed
// time-keeping sequences and randomized stimulus against a behavioural model.
module tb_clock_face_renderer;

    localparam int FPS = 75;
    localparam int X0  = 144;
    localparam int Y0  = 168;
    localparam int DW  = 80;
    localparam int DH  = 144;
    localparam int T   = 16;
    localparam int P   = 96;
    localparam int CX  = X0 + P + DW + (P - DW - T) / 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] vga_x = '0;
    logic [9:0] vga_y = '0;
    logic       vga_visible = 1'b0;
    logic       vga_vertical_blank_strobe = 1'b0;
    logic       vga_hs_in = 1'b1;
    logic       vga_vs_in = 1'b1;
    logic       hour_button = 1'b0;
    logic       minute_button = 1'b0;
    logic [1:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs;
    logic [7:0] seconds;

    clock_face_renderer dut (
        .clock                     (clock),
        .reset                     (reset),
        .vga_x                     (vga_x),
        .vga_y                     (vga_y),
        .vga_visible               (vga_visible),
        .vga_vertical_blank_strobe (vga_vertical_blank_strobe),
        .vga_hs_in                 (vga_hs_in),
        .vga_vs_in                 (vga_vs_in),
        .hour_button               (hour_button),
        .minute_button             (minute_button),
        .vga_r                     (vga_r),
        .vga_g                     (vga_g),
        .vga_b                     (vga_b),
        .vga_hs                    (vga_hs),
        .vga_vs                    (vga_vs),
        .seconds                   (seconds)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: plain integers for time, frames and button history
    int m_hh, m_mm, m_ss, m_fc;
    bit m_hprev, m_mprev;

    string seg_on [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                           "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
    string letters = "abcdefg";

    typedef struct {
        int x;
        int y;
        bit vis;
        int exp_rgb;
    } pix_vec_t;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    function automatic int bcd(input int n);
        return (n / 10) * 16 + (n % 10);
    endfunction

    function automatic int rgb_now();
        return int'({vga_r, vga_g, vga_b});
    endfunction

    task automatic model_reset();
        m_hh = 0; m_mm = 0; m_ss = 0; m_fc = 0;
        m_hprev = 0; m_mprev = 0;
    endtask

    // One frame boundary as seen by the model, using the held button levels
    task automatic model_frame();
        bit hp, mp, tick, hcarry;
        hp = hour_button && !m_hprev;
        mp = minute_button && !m_mprev;
        m_hprev = hour_button;
        m_mprev = minute_button;
        tick = (m_fc == FPS - 1);
        m_fc = (m_fc + 1) % FPS;
        hcarry = 0;
        if (mp) begin
            m_mm = (m_mm + 1) % 60;
            m_ss = 0;
            m_fc = 0;
        end else if (tick) begin
            m_ss++;
            if (m_ss == 60) begin
                m_ss = 0;
                m_mm++;
                if (m_mm == 60) begin
                    m_mm = 0;
                    hcarry = 1;
                end
            end
        end
        if (hp || hcarry) m_hh = (m_hh + 1) % 24;
    endtask

    function automatic bit has_seg(input int d, input byte c);
        for (int i = 0; i < seg_on[d].len(); i++)
            if (seg_on[d][i] == c) return 1;
        return 0;
    endfunction

    function automatic bit in_seg(input byte c, input int lx, input int ly);
        case (c)
            "a": return ly < T;
            "b": return lx >= DW - T && ly < DH / 2;
            "c": return lx >= DW - T && ly >= DH / 2;
            "d": return ly >= DH - T;
            "e": return lx < T && ly >= DH / 2;
            "f": return lx < T && ly < DH / 2;
            "g": return ly >= DH / 2 - T / 2 && ly < DH / 2 + T / 2;
            default: return 0;
        endcase
    endfunction

    function automatic int model_rgb(input int x, input int y, input bit vis);
        int digs[4];
        bit colon_on;
        if (!vis) return 0;
        digs[0] = m_hh / 10; digs[1] = m_hh % 10;
        digs[2] = m_mm / 10; digs[3] = m_mm % 10;
        for (int i = 0; i < 4; i++) begin
            int ox = X0 + i * P;
            if (x >= ox && x < ox + DW && y >= Y0 && y < Y0 + DH) begin
                for (int k = 0; k < 7; k++) begin
                    byte c = letters[k];
                    if (has_seg(digs[i], c) && in_seg(c, x - ox, y - Y0)) return 60;
                end
            end
        end
`ifdef CLOCK_FACE_COLON_BLINK_EN
        colon_on = (m_ss % 2 == 0);
`else
        colon_on = 1;
`endif
        if (colon_on && x >= CX && x < CX + T &&
            ((y >= Y0 + 40 && y < Y0 + 40 + T) || (y >= Y0 + 96 && y < Y0 + 96 + T)))
            return 63;
        return 1;
    endfunction

    // Hold the buttons for two cycles so the synchronizer settles, then strobe
    task automatic strobe_frame();
        @(negedge clock);
        @(negedge clock);
        vga_vertical_blank_strobe = 1'b1;
        model_frame();
        @(negedge clock);
        vga_vertical_blank_strobe = 1'b0;
    endtask

    task automatic press(input bit h, input bit m);
        hour_button = h;
        minute_button = m;
        strobe_frame();
        hour_button = 1'b0;
        minute_button = 1'b0;
        strobe_frame();
    endtask

    task automatic probe(input string name, input int x, input int y, input bit vis);
        vga_x = 10'(x);
        vga_y = 10'(y);
        vga_visible = vis;
        @(negedge clock);
        check(name, rgb_now(), model_rgb(x, y, vis));
    endtask

    task automatic check_seconds(input string name);
        check(name, int'(seconds), bcd(m_ss));
    endtask

    // Probe every segment centre of every digit plus both colon squares
    task automatic check_display(input string tag);
        int cx[7] = '{DW / 2, DW - T / 2, DW - T / 2, DW / 2, T / 2, T / 2, DW / 2};
        int cy[7] = '{T / 2, DH / 4, 3 * DH / 4, DH - T / 2, 3 * DH / 4, DH / 4, DH / 2};
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 7; k++)
                probe($sformatf("%s_d%0d_s%0d", tag, i, k), X0 + i * P + cx[k], Y0 + cy[k], 1'b1);
        probe($sformatf("%s_colon_hi", tag), CX + T / 2, Y0 + 48, 1'b1);
        probe($sformatf("%s_colon_lo", tag), CX + T / 2, Y0 + 104, 1'b1);
    endtask

    task automatic run_to_wrap(input string name);
        int reached = 0;
        for (int i = 0; i < 6000 && reached == 0; i++) begin
            if (m_ss == 59 && m_fc == FPS - 1) reached = 1;
            else strobe_frame();
        end
        check(name, reached, 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pix_vec_t vecs[18];
        int reached;
        int colon_exp;

        // Expected colours at 12:34:00: 60 = (3,3,0), 63 = (3,3,3), 1 = (0,0,1)
        vecs = '{
            '{X0 + 40,        Y0 + 4,   1'b1, 1},
            '{X0 + P + 4,     Y0 + 4,   1'b1, 60},
            '{X0 + P + 4,     Y0 + 4,   1'b0, 0},
            '{X0 + 70,        Y0 + 30,  1'b1, 60},
            '{X0 + 2*P + 40,  Y0 + 72,  1'b1, 60},
            '{X0 + 3*P + 40,  Y0 + 4,   1'b1, 1},
            '{X0 + 3*P + 4,   Y0 + 30,  1'b1, 60},
            '{CX + 8,         Y0 + 48,  1'b1, 63},
            '{CX + 8,         Y0 + 104, 1'b1, 63},
            '{CX + 8,         Y0 + 70,  1'b1, 1},
            '{X0 - 1,         Y0 + 4,   1'b1, 1},
            '{X0 + P + 40,    Y0 + 140, 1'b1, 60},
            '{1023,           Y0 + 4,   1'b1, 1},
            '{X0 + P + 79,    Y0 + 30,  1'b1, 60},
            '{X0 + P + 80,    Y0 + 30,  1'b1, 1},
            '{X0 + 3*P + 4,   Y0 + 100, 1'b1, 1},
            '{X0 + P + 40,    Y0 + 144, 1'b1, 1},
            '{X0 + P + 72,    Y0 + 100, 1'b1, 1}
        };

        // Reset with inputs that would otherwise produce visible activity
        reset = 1'b1;
        vga_hs_in = 1'b0;
        vga_vs_in = 1'b0;
        vga_visible = 1'b1;
        vga_x = 10'(X0 + 40);
        vga_y = 10'(Y0 + 4);
        repeat (3) @(negedge clock);
        check("reset_rgb", rgb_now(), 0);
        check("reset_hs", int'(vga_hs), 1);
        check("reset_vs", int'(vga_vs), 1);
        check("reset_seconds", int'(seconds), 0);
        reset = 1'b0;
        vga_hs_in = 1'b1;
        vga_vs_in = 1'b1;
        model_reset();
        @(negedge clock);
        check_display("rst");

        // Sync outputs follow their inputs exactly one cycle later
        vga_hs_in = 1'b0;
        #1 check("hs_hold", int'(vga_hs), 1);
        @(negedge clock);
        check("hs_delay", int'(vga_hs), 0);
        check("vs_still", int'(vga_vs), 1);
        vga_hs_in = 1'b1;
        vga_vs_in = 1'b0;
        #1 check("vs_hold", int'(vga_vs), 1);
        @(negedge clock);
        check("vs_delay", int'(vga_vs), 0);
        check("hs_back", int'(vga_hs), 1);
        vga_vs_in = 1'b1;
        @(negedge clock);

        // One minute of frames
        for (int k = 1; k <= 60 * FPS; k++) begin
            strobe_frame();
            if (k == FPS - 1)     check("sec_before_tick", int'(seconds), 8'h00);
            if (k == FPS)         check("sec_first_tick", int'(seconds), 8'h01);
            if (k == 2 * FPS - 1) check("sec_fc_wrapped", int'(seconds), 8'h01);
            if (k == 2 * FPS)     check("sec_second_tick", int'(seconds), 8'h02);
        end
        check("sec_one_minute", int'(seconds), 8'h00);
        check_display("min1");

        // Set 12:34 using simultaneous presses, then minute-only presses
        for (int i = 0; i < 12; i++) press(1'b1, 1'b1);
        for (int i = 0; i < 21; i++) press(1'b0, 1'b1);
        check("sec_after_set", int'(seconds), 8'h00);
        check_display("t1234");
        foreach (vecs[i]) probe($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].vis);

        // Colon at an odd second
        reached = 0;
        for (int i = 0; i < 200 && reached == 0; i++) begin
            if (m_ss == 1) reached = 1;
            else strobe_frame();
        end
        check("reach_sec01", reached, 1);
        check("sec01", int'(seconds), 8'h01);
`ifdef CLOCK_FACE_COLON_BLINK_EN
        colon_exp = 1;
`else
        colon_exp = 63;
`endif
        vga_x = 10'(CX + 8);
        vga_y = 10'(Y0 + 48);
        vga_visible = 1'b1;
        @(negedge clock);
        check("colon_sec01", rgb_now(), colon_exp);

        // Minute button held across three frames counts once
        minute_button = 1'b1;
        repeat (3) strobe_frame();
        minute_button = 1'b0;
        strobe_frame();
        check("held_seconds", int'(seconds), 8'h00);
        check_display("held");
        press(1'b0, 1'b1);
        check_display("repress");

        // Minute press in the frame where 59 s would wrap
        run_to_wrap("reach_wrap_a");
        check("sec59_a", int'(seconds), 8'h59);
        minute_button = 1'b1;
        strobe_frame();
        minute_button = 1'b0;
        check("press_at_wrap_sec", int'(seconds), 8'h00);
        check_display("pwrap");
        strobe_frame();

        // Preload 23:59:59 then let one tick roll the day over
        for (int i = 0; i < 24 && m_hh != 23; i++) press(1'b1, 1'b0);
        for (int i = 0; i < 60 && m_mm != 59; i++) press(1'b0, 1'b1);
        run_to_wrap("reach_wrap_b");
        check("sec59_b", int'(seconds), 8'h59);
        check_display("t2359");
        strobe_frame();
        check("rollover_sec", int'(seconds), 8'h00);
        check_display("t0000");

        // Randomized frames, button activity and pixel probes
        for (int it = 0; it < 300; it++) begin
            int op = int'($urandom_range(0, 3));
            if (op < 2) begin
                int x, y;
                x = ($urandom_range(0, 1) == 0) ? int'($urandom_range(100, 480)) : int'($urandom_range(0, 1023));
                y = ($urandom_range(0, 1) == 0) ? int'($urandom_range(150, 330)) : int'($urandom_range(0, 1023));
                probe($sformatf("rnd%0d_pix", it), x, y, $urandom_range(0, 4) != 0);
            end else if (op == 2) begin
                hour_button = ($urandom_range(0, 3) == 0);
                minute_button = ($urandom_range(0, 3) == 0);
                strobe_frame();
                check_seconds($sformatf("rnd%0d_sec", it));
            end else begin
                hour_button = 1'b0;
                minute_button = 1'b0;
                repeat (25) strobe_frame();
                check_seconds($sformatf("rnd%0d_run", it));
            end
        end
        hour_button = 1'b0;
        minute_button = 1'b0;
        strobe_frame();
        check_display("rnd_end");

        // Reset in the middle of a frame
        press(1'b1, 1'b1);
        repeat (80) strobe_frame();
        vga_x = 10'(X0 + P + 70);
        vga_y = 10'(Y0 + 30);
        vga_visible = 1'b1;
        vga_hs_in = 1'b0;
        vga_vs_in = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check("midrst_rgb", rgb_now(), 0);
        check("midrst_hs", int'(vga_hs), 1);
        check("midrst_vs", int'(vga_vs), 1);
        check("midrst_seconds", int'(seconds), 0);
        reset = 1'b0;
        vga_hs_in = 1'b1;
        vga_vs_in = 1'b1;
        model_reset();
        @(negedge clock);
        check_display("midrst");
        repeat (FPS) strobe_frame();
        check("midrst_first_tick", int'(seconds), 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
